interboard_msg_arbiter: RTL
===========================

INTERBOARD_MSG_ARBITER -- requirements
Module: interboard_msg_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of message requesters (handle_* blocks); legal values 2..8.
REQ-002 SHALL have port clk, input, 1, system clock; sole clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high local reset.
REQ-004 SHALL have port interboard_rst, input, 1, synchronous active-high reset from the peer board; same effect as rst.
REQ-005 SHALL have port req_en, input, NUM_REQ, one-cycle request pulse per requester.
REQ-006 SHALL have port req_msg, input, NUM_REQ*22, per-requester packed {move_dir[1], block_x[5], block_y[3], msg_type[4], card[6], sel_len[3]}; slice i = bits [22*i+21 : 22*i].
REQ-007 SHALL have port inter_ready, input, 1, interboard transmitter idle.
REQ-008 SHALL have ports ctrl_en (1), ctrl_move_dir (1), ctrl_block_x (5), ctrl_block_y (3), ctrl_msg_type (4), ctrl_card (6), ctrl_sel_len (3), all outputs, message to the interboard transmitter.
REQ-009 SHALL have port req_pending, output, NUM_REQ, slot i holds an unsent message.
REQ-010 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-011 SHALL keep one pending slot per requester; req_en[i] with slot i empty captures req_msg slice i and sets req_pending[i] on the next edge.
REQ-012 SHALL drop req_en[i] while slot i is pending; the stored message is left unchanged.
REQ-013 SHALL run FSM IDLE -> SEND -> WAIT_LOW -> WAIT_HIGH -> IDLE.
REQ-014 In IDLE with any req_pending bit set and inter_ready=1, SHALL select the winner by round-robin, starting at index (last_grant+1) mod NUM_REQ and searching upward with wrap-around; SHALL then enter SEND.
REQ-015 In SEND, SHALL drive ctrl_en=1 for exactly one cycle with the ctrl_* fields equal to the winner's slot; SHALL clear that slot's pending bit; SHALL set last_grant=winner; SHALL then go to WAIT_LOW.
REQ-016 SHALL stay in WAIT_LOW until inter_ready=0, then go to WAIT_HIGH.
REQ-017 SHALL stay in WAIT_HIGH until inter_ready=1, then go to IDLE; a new grant is possible in that same IDLE cycle.
REQ-018 Latency: a request into an empty arbiter with inter_ready=1 SHALL produce ctrl_en 2 cycles after the req_en pulse (capture edge, then the IDLE grant edge).
REQ-019 SHALL accept req_en for the granted slot in the same cycle its pending bit clears; that request is captured and becomes pending again.
REQ-020 SHALL not grant from IDLE while inter_ready=0.
REQ-021 Outside SEND, ctrl_en SHALL be 0 and the ctrl_* fields SHALL hold the last sent values.
REQ-022 Multiple simultaneous req_en pulses SHALL all be captured in the same cycle.

Reset
REQ-023 rst or interboard_rst SHALL, on the clock edge, clear all pending slots and stored messages, set FSM=IDLE, ctrl_en=0, all ctrl_* fields=0, last_grant=NUM_REQ-1 (so requester 0 wins first), busy=0, and (if compiled in) ovf_err=0.
REQ-024 Reset in any state, including SEND, SHALL abort the transfer; no ctrl_en SHALL follow in the next cycle.
REQ-025 req_en coincident with reset SHALL be discarded.

Configuration
REQ-026 With macro ARB_OVERFLOW_FLAG_EN defined, SHALL add output ovf_err (NUM_REQ): bit i is set sticky when REQ-012 drops a request on slot i, and cleared only by reset.
REQ-027 Without ARB_OVERFLOW_FLAG_EN, the ovf_err port and its logic SHALL be absent; drop behaviour is unchanged.

Structure
REQ-028 The message field widths, the 22-bit packed layout and the FSM state encodings SHALL live in the shared message macro header, alongside the msg_type codes.
REQ-029 The round-robin pick SHALL be one sub-module, rr_picker (inputs pending, last_grant; outputs winner, valid), combinational.

Verification
REQ-030 Single request: reset, then req_en[2] with msg_type=5 and card=17, inter_ready=1 -> ctrl_en high 2 cycles later with msg_type=5 and card=17; req_pending[2] clears.
REQ-031 All four req_en pulse together, transmitter model drops ready 1 cycle after ctrl_en and restores it 3 cycles later -> four ctrl_en pulses in requester order 0, 1, 2, 3, each separated by the handshake.
REQ-032 Fairness: requester 1 re-pulses immediately after each grant while requesters 2 and 3 stay pending -> grant order 1, 2, 3, 1.
REQ-033 Overflow: req_en[0] twice while slot 0 is pending with a different block_x -> first block_x sent; with ARB_OVERFLOW_FLAG_EN, ovf_err[0]=1.
REQ-034 interboard_rst asserted during WAIT_HIGH with 2 slots pending -> next cycle IDLE, req_pending=0, no ctrl_en.
REQ-035 inter_ready held 0 with slot 3 pending -> no ctrl_en; raising inter_ready -> ctrl_en in the next cycle.

Source files
------------

// File: rtl/interboard_msg_arbiter_pkg.sv
// Shared message layout, field widths, msg_type codes and FSM encodings
// for the interboard message arbiter.
package interboard_msg_arbiter_pkg;

  localparam int MOVE_DIR_W = 1;
  localparam int BLOCK_X_W  = 5;
  localparam int BLOCK_Y_W  = 3;
  localparam int MSG_TYPE_W = 4;
  localparam int CARD_W     = 6;
  localparam int SEL_LEN_W  = 3;
  localparam int MSG_W      = MOVE_DIR_W + BLOCK_X_W + BLOCK_Y_W + MSG_TYPE_W + CARD_W + SEL_LEN_W;

  // Packed order matches the req_msg slice: move_dir is the MSB, sel_len the LSBs.
  typedef struct packed {
    logic [MOVE_DIR_W-1:0] move_dir;
    logic [BLOCK_X_W-1:0]  block_x;
    logic [BLOCK_Y_W-1:0]  block_y;
    logic [MSG_TYPE_W-1:0] msg_type;
    logic [CARD_W-1:0]     card;
    logic [SEL_LEN_W-1:0]  sel_len;
  } msg_t;

  localparam logic [MSG_TYPE_W-1:0] MSG_NOP     = 4'd0;
  localparam logic [MSG_TYPE_W-1:0] MSG_MOVE    = 4'd1;
  localparam logic [MSG_TYPE_W-1:0] MSG_SELECT  = 4'd2;
  localparam logic [MSG_TYPE_W-1:0] MSG_PLAY    = 4'd3;
  localparam logic [MSG_TYPE_W-1:0] MSG_DISCARD = 4'd4;
  localparam logic [MSG_TYPE_W-1:0] MSG_SYNC    = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_LOW  = 2'd2,
    ST_WAIT_HIGH = 2'd3
  } arb_state_t;

endpackage

// File: rtl/interboard_msg_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending index above last_grant,
// searching upward with wrap-around.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  // Scan farthest-to-nearest so the nearest pending index is the last write.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (pending[(int'(last_grant) + k) % NUM_REQ]) begin
        winner = IDX_W'((int'(last_grant) + k) % NUM_REQ);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interboard_msg_arbiter.sv
// Round-robin arbiter feeding one interboard transmitter from NUM_REQ
// single-slot requesters. Optional sticky drop flags under ARB_OVERFLOW_FLAG_EN.
//
// state        | meaning
// ST_IDLE      | waiting for a pending slot and inter_ready=1
// ST_SEND      | ctrl_en high for one cycle with the winner's message
// ST_WAIT_LOW  | waiting for the transmitter to drop inter_ready
// ST_WAIT_HIGH | waiting for the transmitter to raise inter_ready
module interboard_msg_arbiter
  import interboard_msg_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   interboard_rst,
  input  logic [NUM_REQ-1:0]     req_en,
  input  logic [NUM_REQ*MSG_W-1:0] req_msg,
  input  logic                   inter_ready,
  output logic                   ctrl_en,
  output logic                   ctrl_move_dir,
  output logic [4:0]             ctrl_block_x,
  output logic [2:0]             ctrl_block_y,
  output logic [3:0]             ctrl_msg_type,
  output logic [5:0]             ctrl_card,
  output logic [2:0]             ctrl_sel_len,
  output logic [NUM_REQ-1:0]     req_pending,
`ifdef ARB_OVERFLOW_FLAG_EN
  output logic [NUM_REQ-1:0]     ovf_err,
`endif
  output logic                   busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state;
  msg_t               slot_q [NUM_REQ];
  msg_t               ctrl_q;
  logic [NUM_REQ-1:0] pending_q;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               grant_fire;
  logic [NUM_REQ-1:0] clr_vec;
  logic [NUM_REQ-1:0] cap_vec;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_picker (
    .pending    (pending_q),
    .last_grant (last_grant),
    .winner     (pick_idx),
    .valid      (pick_valid)
  );

  assign grant_fire = (state == ST_IDLE) && pick_valid && inter_ready;
  assign clr_vec    = grant_fire ? (NUM_REQ'(1) << pick_idx) : '0;
  // A slot being granted on this edge counts as empty, so its owner can refill it.
  assign cap_vec    = req_en & (~pending_q | clr_vec);

  always_ff @(posedge clk) begin
    if (rst || interboard_rst) begin
      state      <= ST_IDLE;
      pending_q  <= '0;
      ctrl_q     <= '0;
      ctrl_en    <= 1'b0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      for (int i = 0; i < NUM_REQ; i++) slot_q[i] <= '0;
`ifdef ARB_OVERFLOW_FLAG_EN
      ovf_err    <= '0;
`endif
    end else begin
      pending_q <= (pending_q & ~clr_vec) | cap_vec;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cap_vec[i]) slot_q[i] <= req_msg[MSG_W*i +: MSG_W];
      end
`ifdef ARB_OVERFLOW_FLAG_EN
      ovf_err <= ovf_err | (req_en & ~cap_vec);
`endif
      ctrl_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            ctrl_en    <= 1'b1;
            ctrl_q     <= slot_q[pick_idx];
            last_grant <= pick_idx;
            state      <= ST_SEND;
          end
        end
        ST_SEND:      state <= ST_WAIT_LOW;
        ST_WAIT_LOW:  if (!inter_ready) state <= ST_WAIT_HIGH;
        ST_WAIT_HIGH: if (inter_ready) state <= ST_IDLE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  assign ctrl_move_dir = ctrl_q.move_dir;
  assign ctrl_block_x  = ctrl_q.block_x;
  assign ctrl_block_y  = ctrl_q.block_y;
  assign ctrl_msg_type = ctrl_q.msg_type;
  assign ctrl_card     = ctrl_q.card;
  assign ctrl_sel_len  = ctrl_q.sel_len;
  assign req_pending   = pending_q;
  assign busy          = (state != ST_IDLE);

endmodule
